lo_code_gen: RTL and testbench
==============================

LO_CODE_GEN -- requirements
Module: lo_code_gen

Interface
REQ-001 SHALL have parameter DIV_W, default 8, meaning the width of the step-divider input and internal prescale counter.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  step enable; when low, all state holds.
REQ-005 SHALL have port dir  input  1  step direction: 0 = index increments, 1 = index decrements.
REQ-006 SHALL have port div  input  DIV_W  step period minus one; a step occurs every div+1 enabled cycles.
REQ-007 SHALL have port load  input  1  one-cycle request to jump to load_idx.
REQ-008 SHALL have port load_idx  input  5  target index for load.
REQ-009 SHALL have port code  output  6  registered 6-bit LO phase code for the current index.
REQ-010 SHALL have port idx  output  5  registered current index, range 0..19.
REQ-011 SHALL have port wrap  output  1  one-cycle pulse on the edge where idx wraps.
REQ-012 SHALL have port load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-013 SHALL map idx to code with this fixed table, idx 0..19: 03,02,06,0D,0F,0B,19,1F,1C,10,30,3C,3F,39,2B,2F,2D,26,22,23 (hex).
REQ-014 SHALL update code on the same edge as idx, so the pair is always consistent (zero-cycle skew, one register stage).
REQ-015 SHALL keep a prescale counter cnt; while en=1 and cnt < div, cnt increments; when cnt >= div, the cycle is a step cycle and cnt clears to 0.
REQ-016 SHALL, on a step cycle with dir=0, set idx to idx+1, wrapping 19 -> 0, with wrap=1 on that wrap.
REQ-017 SHALL, on a step cycle with dir=1, set idx to idx-1, wrapping 0 -> 19, with wrap=1 on that wrap.
REQ-018 SHALL hold cnt, idx, and code while en=0; wrap SHALL be 0 on any non-step cycle.
REQ-019 SHALL step on every enabled cycle when div=0.
REQ-020 SHALL compare against the live div value; lowering div below cnt causes a step on the next enabled cycle (the >= rule).
REQ-021 SHALL sample dir only on step cycles; a dir change mid-period affects only the next step.
REQ-022 SHALL, on load=1 with load_idx <= 19, set idx to load_idx, set code to its table value, and clear cnt to 0, regardless of en; wrap=0 on that cycle.
REQ-023 SHALL, on load=1 with load_idx >= 20, leave idx, code, and cnt unchanged (stepping proceeds normally) and pulse load_err for one cycle.
REQ-024 SHALL give a valid load priority over a simultaneous step: the step is discarded.
REQ-025 SHALL never let idx hold a value >= 20.

Reset
REQ-026 SHALL, while rst=1 at a rising edge, set idx=0, code=6'h03, cnt=0, wrap=0, load_err=0; rst SHALL take priority over load and en.
REQ-027 SHALL treat rst asserted mid-period as an abort: the partial count is discarded and the first step after release comes div+1 enabled cycles later.

Structure
REQ-028 SHALL place the 20-entry code table, the constant NUM_PHASES=20, and the constant IDX_W=5 in the shared package lo_pkg, where the gray_decoder side can also use them.
REQ-029 SHALL implement the index-to-code lookup in the combinational sub-module lo_code_rom (5-bit in, 6-bit out, out-of-range input gives 6'h00); the top-level module registers its output.

Verification
REQ-030 SHALL cover: reset, then en=1, dir=0, div=0 for 21 cycles -> code walks 03,02,06,...,22,23,03; wrap=1 only on the 19->0 edge.
REQ-031 SHALL cover: dir=1, div=2 from idx=0 -> idx=19, code=23 after 3 enabled cycles, with wrap=1; next step after 3 more cycles gives idx=18, code=22.
REQ-032 SHALL cover: load=1, load_idx=12 on the same cycle as a step -> idx=12, code=3F, cnt=0, wrap=0; then load_idx=25 -> load_err pulse, idx unchanged.
REQ-033 SHALL cover: div=7 with en toggled low for 5 cycles mid-period -> idx/code/cnt hold; the step lands after 8 total enabled cycles; then lower div to 1 while cnt=5 -> step on the next enabled cycle.
REQ-034 SHALL cover: rst asserted for 1 cycle with idx=9 and cnt mid-period, while load=1 -> idx=0, code=03, and the load is ignored.
REQ-035 SHALL cover: loopback through gray_decoder on every cycle -> exactly one decoder output is high, and it equals idx.

Source files
------------

// File: rtl/lo_pkg.sv
// Shared LO phase-code definitions, used by the code generator and the gray_decoder side.
package lo_pkg;

    localparam int NUM_PHASES = 20;
    localparam int IDX_W      = 5;
    localparam int CODE_W     = 6;

    // Phase code per index. Packed, so entry 0 is the rightmost literal.
    localparam logic [NUM_PHASES-1:0][CODE_W-1:0] CODE_TAB = {
        6'h23, 6'h22, 6'h26, 6'h2D, 6'h2F, 6'h2B, 6'h39, 6'h3F, 6'h3C, 6'h30,
        6'h10, 6'h1C, 6'h1F, 6'h19, 6'h0B, 6'h0F, 6'h0D, 6'h06, 6'h02, 6'h03
    };

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_PHASES - 1);
    localparam logic [CODE_W-1:0] CODE_RST  = CODE_TAB[0];

endpackage

// File: rtl/lo_code_rom.sv
// Combinational index-to-phase-code lookup; indices outside the table read as zero.
module lo_code_rom
    import lo_pkg::*;
(
    input  logic [IDX_W-1:0]  addr,
    output logic [CODE_W-1:0] code
);

    // Compare against every legal index so out-of-range addresses never select past the table.
    always_comb begin
        code = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (addr == IDX_W'(i)) code = CODE_TAB[i];
        end
    end

endmodule

// File: rtl/lo_code_gen.sv
// LO phase-code sequencer: prescaled up/down walk over a 20-entry code table with load.
module lo_code_gen
    import lo_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              dir,
    input  logic [DIV_W-1:0]  div,
    input  logic              load,
    input  logic [IDX_W-1:0]  load_idx,
    output logic [CODE_W-1:0] code,
    output logic [IDX_W-1:0]  idx,
    output logic              wrap,
    output logic              load_err
);

    logic [DIV_W-1:0]  cnt;
    logic [DIV_W-1:0]  cnt_d;
    logic [IDX_W-1:0]  idx_d;
    logic              wrap_d;
    logic              load_ok;
    logic [CODE_W-1:0] code_d;

    assign load_ok = load && (load_idx < IDX_W'(NUM_PHASES));

    // Next index/count: a valid load beats a step; >= against live div so a lowered div steps at once.
    always_comb begin
        idx_d  = idx;
        cnt_d  = cnt;
        wrap_d = 1'b0;
        if (load_ok) begin
            idx_d = load_idx;
            cnt_d = '0;
        end else if (en) begin
            if (cnt >= div) begin
                cnt_d = '0;
                if (dir) begin
                    if (idx == '0) begin
                        idx_d  = IDX_LAST;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx - IDX_W'(1);
                    end
                end else begin
                    if (idx == IDX_LAST) begin
                        idx_d  = '0;
                        wrap_d = 1'b1;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end else begin
                cnt_d = cnt + DIV_W'(1);
            end
        end
    end

    // Look up the code for the next index so idx and code register on the same edge.
    lo_code_rom u_rom (
        .addr (idx_d),
        .code (code_d)
    );

    // State and output registers; reset wins over load and enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx      <= '0;
            code     <= CODE_RST;
            cnt      <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            idx      <= idx_d;
            code     <= code_d;
            cnt      <= cnt_d;
            wrap     <= wrap_d;
            load_err <= load && !load_ok;
        end
    end

endmodule

// File: tb/tb_lo_code_gen.sv
// Directed bench for lo_code_gen: cycle-by-cycle vectors with hand-computed idx/wrap/load_err.
module tb_lo_code_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] div = '0;
    logic       load = 1'b0;
    logic [4:0] load_idx = '0;
    logic [5:0] code;
    logic [4:0] idx;
    logic       wrap;
    logic       load_err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [5:0] tab [20];

    typedef struct {
        logic       rst, en, dir;
        logic [7:0] div;
        logic       load;
        logic [4:0] lidx;
        int         eidx;
        logic       ewrap, eerr;
    } vec_t;

    vec_t vq[$];

    lo_code_gen #(.DIV_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .dir      (dir),
        .div      (div),
        .load     (load),
        .load_idx (load_idx),
        .code     (code),
        .idx      (idx),
        .wrap     (wrap),
        .load_err (load_err)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic r, logic e, logic d, int dv, logic l, int li,
                                int ei, logic ew, logic ee);
        vec_t v;
        v.rst = r; v.en = e; v.dir = d; v.div = 8'(dv); v.load = l; v.lidx = 5'(li);
        v.eidx = ei; v.ewrap = ew; v.eerr = ee;
        return v;
    endfunction

    function automatic void add(logic r, logic e, logic d, int dv, logic l, int li,
                                int ei, logic ew, logic ee);
        vq.push_back(mk(r, e, d, dv, l, li, ei, ew, ee));
    endfunction

    task automatic check(input string name, input int step, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %0h, expected %0h", name, step, act, exp);
        end
    endtask

    // Drive one cycle, then check every output plus the gray-decoder loopback.
    task automatic apply(input vec_t v, input int step);
        logic [19:0] hot;
        rst = v.rst; en = v.en; dir = v.dir; div = v.div;
        load = v.load; load_idx = v.lidx;
        @(posedge clk);
        #1;
        check("idx", step, int'(idx), v.eidx);
        check("code", step, int'(code), int'(tab[v.eidx]));
        check("wrap", step, int'(wrap), int'(v.ewrap));
        check("load_err", step, int'(load_err), int'(v.eerr));
        hot = '0;
        for (int i = 0; i < 20; i++) hot[i] = (code == tab[i]);
        n_cmp++;
        if ($countones(hot) != 1 || idx > 5'd19 || hot != (20'd1 << idx)) begin
            n_bad++;
            $display("FAIL loopback step %0d: decoder %05h, expected one-hot of idx %0d", step, hot, idx);
        end
    endtask

    initial begin
        int s;
        tab = '{6'h03, 6'h02, 6'h06, 6'h0D, 6'h0F, 6'h0B, 6'h19, 6'h1F, 6'h1C, 6'h10,
                6'h30, 6'h3C, 6'h3F, 6'h39, 6'h2B, 6'h2F, 6'h2D, 6'h26, 6'h22, 6'h23};

        // Reset, then full forward walk at div=0 with wrap on 19->0.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) add(0, 1, 0, 0, 0, 0, k % 20, (k == 20), 0);
        // Reverse at div=2: wrap 0->19 on third enabled cycle, then 18.
        add(0, 1, 1, 2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2, 0, 0, 0, 0, 0);
        add(0, 1, 1, 2, 0, 0, 19, 1, 0);
        add(0, 1, 1, 2, 0, 0, 19, 0, 0);
        add(0, 1, 1, 2, 0, 0, 19, 0, 0);
        add(0, 1, 1, 2, 0, 0, 18, 0, 0);
        // Load on a step cycle wins; rejected load on a step cycle lets the step through.
        add(0, 1, 1, 2, 0, 0, 18, 0, 0);
        add(0, 1, 1, 2, 0, 0, 18, 0, 0);
        add(0, 1, 1, 2, 1, 12, 12, 0, 0);
        add(0, 1, 1, 2, 0, 0, 12, 0, 0);
        add(0, 1, 1, 2, 0, 0, 12, 0, 0);
        add(0, 1, 1, 2, 1, 25, 11, 0, 1);
        // Load while disabled, then a step from 19 wraps forward.
        add(0, 0, 0, 0, 1, 19, 19, 0, 0);
        add(0, 1, 0, 0, 0, 0, 0, 1, 0);

        s = 0;
        foreach (vq[i]) begin
            apply(vq[i], s);
            s++;
        end

        // div=7 with a 5-cycle enable gap: step after 8 enabled cycles.
        apply(mk(0, 0, 0, 7, 1, 5, 5, 0, 0), s++);
        for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 7, 0, 0, 5, 0, 0), s++);
        for (int k = 0; k < 5; k++) apply(mk(0, 0, 0, 7, 0, 0, 5, 0, 0), s++);
        for (int k = 0; k < 4; k++) apply(mk(0, 1, 0, 7, 0, 0, 5, 0, 0), s++);
        apply(mk(0, 1, 0, 7, 0, 0, 6, 0, 0), s++);
        // Count to 5, then drop div to 1: immediate step.
        for (int k = 0; k < 5; k++) apply(mk(0, 1, 0, 7, 0, 0, 6, 0, 0), s++);
        apply(mk(0, 1, 0, 1, 0, 0, 7, 0, 0), s++);
        apply(mk(0, 1, 0, 1, 0, 0, 7, 0, 0), s++);
        apply(mk(0, 1, 0, 1, 0, 0, 8, 0, 0), s++);

        // Reach idx=9 mid-period, then reset with a valid load pending.
        apply(mk(0, 1, 0, 1, 0, 0, 8, 0, 0), s++);
        apply(mk(0, 1, 0, 1, 0, 0, 9, 0, 0), s++);
        apply(mk(0, 1, 0, 3, 0, 0, 9, 0, 0), s++);
        apply(mk(0, 1, 0, 3, 0, 0, 9, 0, 0), s++);
        apply(mk(1, 1, 0, 3, 1, 12, 0, 0, 0), s++);
        // Partial count was discarded: next step after div+1 enabled cycles.
        for (int k = 0; k < 3; k++) apply(mk(0, 1, 0, 3, 0, 0, 0, 0, 0), s++);
        apply(mk(0, 1, 0, 3, 0, 0, 1, 0, 0), s++);
        // dir toggled mid-period only matters on the step cycle.
        for (int k = 0; k < 3; k++) apply(mk(0, 1, 1, 3, 0, 0, 1, 0, 0), s++);
        apply(mk(0, 1, 0, 3, 0, 0, 2, 0, 0), s++);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
